// File: rtl/decode_rename_queue_pkg.sv
// Shared types and sizing for the decode-to-rename queue.
// Holds the decoded-instruction payload, default widths and a contiguity helper.
package decode_rename_queue_pkg;

    localparam int DECQ_DEPTH        = 16;
    localparam int DECQ_DECODE_WIDTH = 4;
    localparam int DECQ_RENAME_WIDTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } decInfo_t;

    // A valid vector is well formed when its set bits form one run starting at bit 0.
    function automatic logic isContiguous(input logic [31:0] v);
        return ((v & (v + 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/decode_rename_queue_popcnt.sv
// Parameterised population count of a valid vector.
// Used by the queue to size the incoming decode group.
module decq_popcnt #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < WIDTH; k++) begin
            cnt_o = cnt_o + CNT_W'(vec_i[k]);
        end
    end

endmodule

// File: rtl/decode_rename_queue.sv
// In-order flop-based FIFO between decode and rename with group enqueue/dequeue.
// Outputs come from registered state only, so an entry reaches rename one cycle after enqueue.
module decode_rename_queue
    import decode_rename_queue_pkg::*;
#(
    parameter int DEPTH        = DECQ_DEPTH,
    parameter int DECODE_WIDTH = DECQ_DECODE_WIDTH,
    parameter int RENAME_WIDTH = DECQ_RENAME_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_squash,
    input  logic [DECODE_WIDTH-1:0]           i_decinfo_vld,
    input  decInfo_t [DECODE_WIDTH-1:0]       i_decinfo,
    output logic                              o_can_enq,
    output logic [RENAME_WIDTH-1:0]           o_decinfo_vld,
    output decInfo_t [RENAME_WIDTH-1:0]       o_decinfo,
    input  logic                              i_rename_rdy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EN_W  = $clog2(DECODE_WIDTH + 1);

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    decInfo_t         entry_q [DEPTH];

    logic [EN_W-1:0]  vldCnt;
    logic [EN_W-1:0]  enqN;
    logic [CNT_W-1:0] nOut;
    logic [CNT_W-1:0] deqN;
    logic [CNT_W-1:0] freeSlots;
    logic             canEnq;

    decq_popcnt #(
        .WIDTH (DECODE_WIDTH),
        .CNT_W (EN_W)
    ) u_popcnt (
        .vec_i (i_decinfo_vld),
        .cnt_o (vldCnt)
    );

    // Admission uses only the current occupancy; a same-cycle dequeue is not credited.
    always_comb begin
        freeSlots = CNT_W'(DEPTH) - count_q;
        canEnq    = !rst && (freeSlots >= CNT_W'(DECODE_WIDTH));
        enqN      = (canEnq && !i_squash) ? vldCnt : '0;
        nOut      = (count_q < CNT_W'(RENAME_WIDTH)) ? count_q : CNT_W'(RENAME_WIDTH);
        deqN      = (i_rename_rdy && !i_squash) ? nOut : '0;
        wptr_d    = wptr_q + PTR_W'(enqN);
        rptr_d    = rptr_q + PTR_W'(deqN);
        count_d   = count_q + CNT_W'(enqN) - deqN;
        if (i_squash) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset; enqN is forced to zero during reset and squash.
    always_ff @(posedge clk) begin
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            if (enqN > EN_W'(k)) begin
                entry_q[PTR_W'(wptr_q + PTR_W'(k))] <= i_decinfo[k];
            end
        end
    end

    always_comb begin
        o_can_enq = canEnq;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            o_decinfo_vld[k] = !rst && (nOut > CNT_W'(k));
            o_decinfo[k]     = entry_q[PTR_W'(rptr_q + PTR_W'(k))];
        end
    end

    assert property (@(posedge clk) disable iff (rst) isContiguous(32'(i_decinfo_vld)));
    assert property (@(posedge clk) disable iff (rst) isContiguous(32'(o_decinfo_vld)));
    assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
    assert property (@(posedge clk) disable iff (rst) !((enqN != '0) && !canEnq));

endmodule

// File: tb/tb_decode_rename_queue.sv
// Scoreboard bench for decode_rename_queue: a driver pushes expected entries,
// a negedge monitor pops and compares whatever rename consumes.
module tb_decode_rename_queue;
    import decode_rename_queue_pkg::*;

    localparam int DW    = 4;
    localparam int RW    = 4;
    localparam int DEPTH = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                squash;
    logic                renameRdy;
    logic [DW-1:0]       inVld;
    decInfo_t [DW-1:0]   inInfo;
    logic                canEnq;
    logic [RW-1:0]       outVld;
    decInfo_t [RW-1:0]   outInfo;

    int       checks   = 0;
    int       errors   = 0;
    int       modelCnt = 0;
    int       tagNext  = 1;
    decInfo_t expQ [$];

    decode_rename_queue #(
        .DEPTH        (DEPTH),
        .DECODE_WIDTH (DW),
        .RENAME_WIDTH (RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_squash      (squash),
        .i_decinfo_vld (inVld),
        .i_decinfo     (inInfo),
        .o_can_enq     (canEnq),
        .o_decinfo_vld (outVld),
        .o_decinfo     (outInfo),
        .i_rename_rdy  (renameRdy)
    );

    always #5 clk = ~clk;

    function automatic decInfo_t mk(input int tag);
        decInfo_t d;
        d.pc   = 32'(tag);
        d.inst = 32'(tag) ^ 32'hDEAD_BEEF;
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle; the model decides acceptance and pushes accepted slots at the edge.
    task automatic applyStimulus(input logic [DW-1:0] vld, input int baseTag, input logic rdy,
                                 input logic sq, output bit accepted);
        int            enqN;
        int            deqN;
        int            nOut;
        bit            expCan;
        logic [RW-1:0] expVld;
        inVld     = vld;
        renameRdy = rdy;
        squash    = sq;
        for (int k = 0; k < DW; k++) inInfo[k] = mk(baseTag + k);
        expCan = (DEPTH - modelCnt) >= DW;
        nOut   = (modelCnt < RW) ? modelCnt : RW;
        expVld = '0;
        for (int k = 0; k < RW; k++) if (k < nOut) expVld[k] = 1'b1;
        @(negedge clk);
        checkOutput("can_enq", 64'(canEnq), 64'(expCan));
        checkOutput("out_vld", 64'(outVld), 64'(expVld));
        @(posedge clk);
        enqN = 0;
        if (expCan && !sq) for (int k = 0; k < DW; k++) enqN += int'(vld[k]);
        deqN = (rdy && !sq) ? nOut : 0;
        if (sq) begin
            expQ.delete();
            modelCnt = 0;
        end else begin
            for (int k = 0; k < enqN; k++) expQ.push_back(mk(baseTag + k));
            modelCnt = modelCnt + enqN - deqN;
        end
        accepted = expCan && !sq;
        #1;
    endtask

    task automatic enqGroup(input logic [DW-1:0] vld, input logic rdy);
        bit acc;
        applyStimulus(vld, tagNext, rdy, 1'b0, acc);
        if (acc) tagNext += DW;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 10; i++) begin
            if (modelCnt == 0) break;
            applyStimulus('0, 0, 1'b1, 1'b0, acc);
        end
    endtask

    // Monitor: whenever rename takes the presented group, pop and compare each valid slot.
    always @(negedge clk) begin
        if (!rst && renameRdy && !squash) begin
            for (int k = 0; k < RW; k++) begin
                if (outVld[k]) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL sb_underflow: got valid slot %0d expected none", k);
                    end else begin
                        checkOutput($sformatf("sb_slot%0d", k), outInfo[k], expQ.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        rst       = 1'b1;
        squash    = 1'b0;
        renameRdy = 1'b1;
        inVld     = 4'b1111;
        for (int k = 0; k < DW; k++) inInfo[k] = mk(900 + k);

        // Reset held two cycles with a full group presented.
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_can_enq", 64'(canEnq), 64'd0);
            checkOutput("rst_out_vld", 64'(outVld), 64'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus('0, 0, 1'b0, 1'b0, acc);
        checkOutput("post_rst_can_enq", 64'(canEnq), 64'd1);

        // Latency and order.
        applyStimulus(4'b1111, 100, 1'b1, 1'b0, acc);
        checkOutput("lat_vld_t1", 64'(outVld), 64'hF);
        checkOutput("lat_slot0", outInfo[0], mk(100));
        checkOutput("lat_slot3", outInfo[3], mk(103));
        applyStimulus('0, 0, 1'b1, 1'b0, acc);
        checkOutput("lat_vld_t2", 64'(outVld), 64'd0);

        // Fill under backpressure, then a held fifth group.
        enqGroup(4'b1111, 1'b0);
        checkOutput("fill4_can", 64'(canEnq), 64'd1);
        enqGroup(4'b1111, 1'b0);
        checkOutput("fill8_can", 64'(canEnq), 64'd1);
        enqGroup(4'b1111, 1'b0);
        checkOutput("fill12_can", 64'(canEnq), 64'd1);
        enqGroup(4'b1111, 1'b0);
        checkOutput("fill16_can", 64'(canEnq), 64'd0);
        checkOutput("fill16_vld", 64'(outVld), 64'hF);
        applyStimulus(4'b1111, tagNext, 1'b0, 1'b0, acc);
        checkOutput("held_can", 64'(canEnq), 64'd0);
        applyStimulus(4'b1111, tagNext, 1'b1, 1'b0, acc);
        checkOutput("after_deq_can", 64'(canEnq), 64'd1);
        enqGroup(4'b1111, 1'b0);
        checkOutput("refill_can", 64'(canEnq), 64'd0);
        drain();

        // Partial groups streaming across the pointer wrap.
        for (int c = 0; c < 40; c++) begin
            case (c % 3)
                0:       enqGroup(4'b0111, 1'b1);
                1:       enqGroup(4'b0001, 1'b1);
                default: enqGroup(4'b0011, 1'b1);
            endcase
        end
        drain();

        // Simultaneous enqueue and dequeue at count 12.
        repeat (3) enqGroup(4'b1111, 1'b0);
        enqGroup(4'b1111, 1'b1);
        checkOutput("simul_can", 64'(canEnq), 64'd1);
        checkOutput("simul_vld", 64'(outVld), 64'hF);
        drain();

        // Squash at count 9 with a group and rename ready in the same cycle.
        enqGroup(4'b1111, 1'b0);
        enqGroup(4'b1111, 1'b0);
        enqGroup(4'b0001, 1'b0);
        applyStimulus(4'b1111, 500, 1'b1, 1'b1, acc);
        checkOutput("squash_vld", 64'(outVld), 64'd0);
        checkOutput("squash_can", 64'(canEnq), 64'd1);
        applyStimulus(4'b0001, 700, 1'b0, 1'b0, acc);
        checkOutput("b0_vld", 64'(outVld), 64'h1);
        checkOutput("b0_data", outInfo[0], mk(700));
        drain();

        checkOutput("sb_leftover", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
